// File: rtl/clock_divider_ctrl.sv
// Quadrature clock divider controller: programmable ratio, boundary-gated start/stop
// and ratio changes, with 0/90 degree outputs registered from the next counter value.
module clock_divider_ctrl #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [DIV_W-1:0] active_div,
    output logic             running,
    output logic             clock_div_0,
    output logic             clock_div_90,
    output logic             phase_strobe
);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             err_q, err_d;
    logic             clk0_q, clk0_d;
    logic             clk90_q, clk90_d;
    logic             strobe_q, strobe_d;
    logic             run_q, run_d;

    logic             xfer;
    logic             legal;
    logic             last;
    logic [DIV_W-1:0] cnt_inc;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] quarter;
    logic [DIV_W-1:0] three_q;
    logic             live;

    assign cfg_ready = (state_q != ST_PEND);
    assign xfer      = cfg_valid && cfg_ready;
    assign legal     = (cfg_div >= DIV_W'(4)) && (cfg_div[1:0] == 2'b00);
    assign last      = (cnt_q == (div_q - DIV_W'(1)));
    assign cnt_inc   = last ? '0 : (cnt_q + DIV_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        err_d   = xfer && !legal;

        case (state_q)
            ST_STOP: begin
                cnt_d = '0;
                if (xfer && legal) begin
                    div_d = cfg_div;
                end
                if (enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                // Stopping at the boundary takes priority; a ratio offered on that
                // edge loads directly since the next period starts from STOP anyway.
                if (last && !enable) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                    if (xfer && legal) begin
                        div_d = cfg_div;
                    end
                end else if (xfer && legal) begin
                    pend_d  = cfg_div;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                cnt_d = cnt_inc;
                if (last) begin
                    div_d   = pend_q;
                    cnt_d   = '0;
                    state_d = enable ? ST_RUN : ST_STOP;
                end
            end
            default: begin
                state_d = ST_STOP;
                cnt_d   = '0;
            end
        endcase
    end

    // Decode against the ratio and count that will be in force after this edge.
    assign half    = div_d >> 1;
    assign quarter = div_d >> 2;
    assign three_q = half + quarter;
    assign live    = (state_d != ST_STOP);

    always_comb begin
        clk0_d   = live && (cnt_d < half);
        clk90_d  = live && (cnt_d >= quarter) && (cnt_d < three_q);
        strobe_d = live && (cnt_d == '0);
        run_d    = live;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_STOP;
            cnt_q    <= '0;
            div_q    <= DIV_W'(DEFAULT_DIV);
            pend_q   <= DIV_W'(DEFAULT_DIV);
            err_q    <= 1'b0;
            clk0_q   <= 1'b0;
            clk90_q  <= 1'b0;
            strobe_q <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
            clk0_q   <= clk0_d;
            clk90_q  <= clk90_d;
            strobe_q <= strobe_d;
            run_q    <= run_d;
        end
    end

    assign cfg_err      = err_q;
    assign active_div   = div_q;
    assign running      = run_q;
    assign clock_div_0  = clk0_q;
    assign clock_div_90 = clk90_q;
    assign phase_strobe = strobe_q;

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl: waveform tables per ratio, handshake,
// illegal ratios, boundary-gated stop, async reset and combined start/config.
`timescale 1ns/1ps
module tb_clock_divider_ctrl;

    localparam int unsigned DIV_W = 8;

    logic             clk;
    logic             reset_n;
    logic             enable;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic [DIV_W-1:0] active_div;
    logic             running;
    logic             clock_div_0;
    logic             clock_div_90;
    logic             phase_strobe;

    int n_cmp = 0;
    int n_bad = 0;

    // {clock_div_0, clock_div_90, phase_strobe} indexed by counter value
    logic [2:0] d4  [4]  = '{3'b101, 3'b110, 3'b010, 3'b000};
    logic [2:0] d8  [8]  = '{3'b101, 3'b100, 3'b110, 3'b110,
                             3'b010, 3'b010, 3'b000, 3'b000};
    logic [2:0] d12 [12] = '{3'b101, 3'b100, 3'b100, 3'b110, 3'b110, 3'b110,
                             3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 3'b000};

    clock_divider_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
        .clock_in     (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .cfg_div      (cfg_div),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .active_div   (active_div),
        .running      (running),
        .clock_div_0  (clock_div_0),
        .clock_div_90 (clock_div_90),
        .phase_strobe (phase_strobe)
    );

    initial clk = 1'b0;
    always #2.5 clk = ~clk;

    function automatic logic [2:0] pat();
        return {clock_div_0, clock_div_90, phase_strobe};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        cfg_div   = '0;
        cfg_valid = 1'b0;

        // reset state
        #12;
        chk("rst_pat", 32'(pat()), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_err", 32'(cfg_err), 32'd0);
        chk("rst_div", 32'(active_div), 32'd4);
        tick();
        reset_n = 1'b1;
        tick();
        chk("stop_pat", 32'(pat()), 32'd0);
        chk("stop_running", 32'(running), 32'd0);

        // default ratio 4
        enable = 1'b1;
        tick();
        chk("d4_start", 32'(pat()), 32'(d4[0]));
        chk("d4_running", 32'(running), 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("d4_c%0d", i), 32'(pat()), 32'(d4[i % 4]));
        end

        // ratio 8 requested mid-period
        tick();
        chk("d4_c0b", 32'(pat()), 32'(d4[0]));
        tick();
        chk("d4_c1b", 32'(pat()), 32'(d4[1]));
        cfg_div   = 8'd8;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("pend_ready", 32'(cfg_ready), 32'd0);
        chk("pend_pat2", 32'(pat()), 32'(d4[2]));
        chk("pend_div", 32'(active_div), 32'd4);
        tick();
        chk("pend_pat3", 32'(pat()), 32'(d4[3]));
        chk("pend_ready3", 32'(cfg_ready), 32'd0);
        tick();
        chk("d8_start", 32'(pat()), 32'(d8[0]));
        chk("d8_div", 32'(active_div), 32'd8);
        chk("d8_ready", 32'(cfg_ready), 32'd1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("d8_c%0d", i), 32'(pat()), 32'(d8[i % 8]));
        end

        // illegal ratios 6 and 2
        tick();
        chk("ill_c0", 32'(pat()), 32'(d8[0]));
        cfg_div   = 8'd6;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("ill6_err", 32'(cfg_err), 32'd1);
        chk("ill6_pat", 32'(pat()), 32'(d8[1]));
        chk("ill6_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("ill6_err_end", 32'(cfg_err), 32'd0);
        chk("ill6_pat2", 32'(pat()), 32'(d8[2]));
        cfg_div   = 8'd2;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("ill2_err", 32'(cfg_err), 32'd1);
        chk("ill2_pat", 32'(pat()), 32'(d8[3]));
        tick();
        chk("ill2_err_end", 32'(cfg_err), 32'd0);
        chk("ill2_pat4", 32'(pat()), 32'(d8[4]));
        chk("ill_div", 32'(active_div), 32'd8);

        // stop requested at cnt 1 finishes the period
        for (int i = 5; i < 10; i++) begin
            tick();
            chk($sformatf("pre_stop_c%0d", i), 32'(pat()), 32'(d8[i % 8]));
        end
        enable = 1'b0;
        for (int i = 2; i < 8; i++) begin
            tick();
            chk($sformatf("drain_c%0d", i), 32'(pat()), 32'(d8[i]));
            chk($sformatf("drain_run%0d", i), 32'(running), 32'd1);
        end
        tick();
        chk("stopped_pat", 32'(pat()), 32'd0);
        chk("stopped_run", 32'(running), 32'd0);
        tick();
        tick();
        chk("stopped_hold", 32'(pat()), 32'd0);
        enable = 1'b1;
        tick();
        chk("restart_pat", 32'(pat()), 32'(d8[0]));
        chk("restart_run", 32'(running), 32'd1);

        // async reset mid-period
        tick();
        tick();
        chk("pre_rst_pat", 32'(pat()), 32'(d8[2]));
        reset_n = 1'b0;
        #1;
        chk("async_pat", 32'(pat()), 32'd0);
        chk("async_run", 32'(running), 32'd0);
        chk("async_div", 32'(active_div), 32'd4);
        enable = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_pat", 32'(pat()), 32'd0);
        chk("post_rst_run", 32'(running), 32'd0);
        chk("post_rst_div", 32'(active_div), 32'd4);
        chk("post_rst_ready", 32'(cfg_ready), 32'd1);

        // ratio 12 together with enable rise
        cfg_div   = 8'd12;
        cfg_valid = 1'b1;
        enable    = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("d12_start", 32'(pat()), 32'(d12[0]));
        chk("d12_div", 32'(active_div), 32'd12);
        chk("d12_err", 32'(cfg_err), 32'd0);
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk($sformatf("d12_c%0d", i), 32'(pat()), 32'(d12[i % 12]));
        end

        // ratio change pending while enable falls: ratio applied, then stop
        cfg_div   = 8'd4;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        enable    = 1'b0;
        chk("pend12_ready", 32'(cfg_ready), 32'd0);
        chk("pend12_pat", 32'(pat()), 32'(d12[1]));
        for (int i = 2; i < 12; i++) begin
            tick();
            chk($sformatf("pend12_c%0d", i), 32'(pat()), 32'(d12[i]));
        end
        chk("pend12_div", 32'(active_div), 32'd12);
        tick();
        chk("pend_stop_pat", 32'(pat()), 32'd0);
        chk("pend_stop_run", 32'(running), 32'd0);
        chk("pend_stop_div", 32'(active_div), 32'd4);
        chk("pend_stop_ready", 32'(cfg_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
